// File: rtl/add_sub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | add_sub_pipe : pipelined add/subtract built from 4-bit lookahead groups,    |
// |                one operand slice per stage, with valid/ready flow control.  |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+

module add_sub_pipe_cla4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_c
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p    = i_a ^ i_b;
    assign w_g    = i_a & i_b;
    assign w_c[0] = i_c;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);
    assign o_s    = w_p ^ w_c[3:0];
    assign o_c    = w_c[4];
endmodule

module add_sub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] RA,
    input  logic [WIDTH-1:0] RB,
    input  logic             sub,
    input  logic             use_cin,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] RC,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / 4;

    logic             w_adv;
    logic [WIDTH-1:0] w_eb;
    logic             w_ecin;
    logic [WIDTH-1:0] w_last_sum;
    logic             w_cmsb;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    assign w_adv    = !(out_valid && !out_ready);
    assign in_ready = w_adv;
    assign w_eb     = sub ? ~RB : RB;
    assign w_ecin   = use_cin ? c_in : sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0]       w_sa;
        logic [SW-1:0]       w_sb;
        logic [SW-1:0]       w_sum;
        logic                w_ci;
        logic                w_vi;
        logic [(k+1)*SW-1:0] w_sn;
        logic [NG:0]         w_gc;
        logic                r_v;
        logic                r_c;
        logic [(k+1)*SW-1:0] r_s;

        if (k == 0) begin : g_src
            assign w_sa = RA[SW-1:0];
            assign w_sb = w_eb[SW-1:0];
            assign w_ci = w_ecin;
            assign w_vi = in_valid;
            assign w_sn = w_sum;
        end else begin : g_src
            assign w_sa = g_stage[k-1].g_hold.r_a[SW-1:0];
            assign w_sb = g_stage[k-1].g_hold.r_b[SW-1:0];
            assign w_ci = g_stage[k-1].r_c;
            assign w_vi = g_stage[k-1].r_v;
            assign w_sn = {w_sum, g_stage[k-1].r_s};
        end

        // Groups ripple their carries across the slice.
        assign w_gc[0] = w_ci;
        for (genvar g = 0; g < NG; g++) begin : g_grp
            add_sub_pipe_cla4 u_cla (
                .i_a (w_sa[4*g +: 4]),
                .i_b (w_sb[4*g +: 4]),
                .i_c (w_gc[g]),
                .o_s (w_sum[4*g +: 4]),
                .o_c (w_gc[g+1])
            );
        end

        if (k < STAGES - 1) begin : g_hold
            localparam int HW = WIDTH - (k + 1) * SW;
            logic [HW-1:0] w_ua;
            logic [HW-1:0] w_ub;
            logic [HW-1:0] r_a;
            logic [HW-1:0] r_b;

            if (k == 0) begin : g_up
                assign w_ua = RA[WIDTH-1:SW];
                assign w_ub = w_eb[WIDTH-1:SW];
            end else begin : g_up
                assign w_ua = g_stage[k-1].g_hold.r_a[HW+SW-1:SW];
                assign w_ub = g_stage[k-1].g_hold.r_b[HW+SW-1:SW];
            end

            always_ff @(posedge clock or posedge clear) begin
                if (clear) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_ua;
                    r_b <= w_ub;
                end
            end
        end

        always_ff @(posedge clock or posedge clear) begin
            if (clear) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_adv) begin
                r_v <= w_vi;
                r_c <= w_gc[NG];
                r_s <= w_sn;
            end
        end
    end

    // Carry into the MSB is recovered from the MSB's own sum bit.
    assign w_last_sum = g_stage[STAGES-1].w_sn;
    assign w_cmsb     = g_stage[STAGES-1].w_sa[SW-1] ^ g_stage[STAGES-1].w_sb[SW-1]
                      ^ g_stage[STAGES-1].w_sum[SW-1];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_adv) begin
            r_ovf  <= w_cmsb ^ g_stage[STAGES-1].w_gc[NG];
            r_zero <= ~|w_last_sum;
            r_neg  <= w_last_sum[WIDTH-1];
        end
    end

    assign out_valid = g_stage[STAGES-1].r_v;
    assign RC        = g_stage[STAGES-1].r_s;
    assign c_out     = g_stage[STAGES-1].r_c;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign neg       = r_neg;
endmodule

`default_nettype wire

// File: tb/tb_add_sub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_add_sub_pipe : scoreboard bench for add_sub_pipe with a reference model. |
// | Revision        : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_add_sub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
);
    localparam int SW = WIDTH / STAGES;

    typedef struct {
        logic [WIDTH-1:0] rc;
        logic             co;
        logic             ov;
        logic             z;
        logic             n;
    } exp_t;

    logic             clock = 1'b0;
    logic             clear = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] RA = '0;
    logic [WIDTH-1:0] RB = '0;
    logic             sub = 1'b0;
    logic             use_cin = 1'b0;
    logic             c_in = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] RC;
    logic             c_out;
    logic             ovf;
    logic             zero;
    logic             neg;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_stall  = 0;
    int   rmode    = 0;

    add_sub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clock     (clock),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .RA        (RA),
        .RB        (RB),
        .sub       (sub),
        .use_cin   (use_cin),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .RC        (RC),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clock = ~clock;

    // Consumer readiness: 0 = always ready, 1 = stalled, 2 = random.
    always @(posedge clock) begin
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom % 3) != 0;
        endcase
    end

    // Reference: true integer sum of A, effective B and carry-in.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s, input logic uc, input logic ci);
        exp_t           m;
        logic [WIDTH:0] full;
        logic [WIDTH-1:0] be;
        logic           cin;
        be   = s ? ~b : b;
        cin  = uc ? ci : s;
        full = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, cin};
        m.rc = full[WIDTH-1:0];
        m.co = full[WIDTH];
        m.ov = (a[WIDTH-1] == be[WIDTH-1]) && (m.rc[WIDTH-1] != a[WIDTH-1]);
        m.z  = (m.rc == '0);
        m.n  = m.rc[WIDTH-1];
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return {1'b0, {(WIDTH-1){1'b1}}};
            default: return r[WIDTH-1:0];
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: pops the oldest expected result on every handoff.
    always @(negedge clock) begin : mon
        exp_t e;
        if (!clear) begin
            chk("in_ready", 128'(in_ready), 128'(!(out_valid && !out_ready)));
            if (!in_ready) n_stall++;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got RC=%h, required no result", RC);
                end else begin
                    e = q.pop_front();
                    chk("result", 128'({RC, c_out, ovf, zero, neg}),
                        128'({e.rc, e.co, e.ov, e.z, e.n}));
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit s, input bit uc, input bit ci, output bit acc);
        in_valid = v;
        RA = a;
        RB = b;
        sub = s;
        use_cin = uc;
        c_in = ci;
        @(negedge clock);
        acc = v && in_ready;
        if (acc) q.push_back(model(a, b, s, uc, ci));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        bit acc;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit s, input bit uc, input bit ci);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 200) begin
            drive(1'b1, a, b, s, uc, ci, acc);
            tries++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no acceptance in %0d cycles, required acceptance", tries);
        end
    endtask

    task automatic drain();
        int t;
        rmode = 0;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            idle();
            t++;
        end
        chk("drain_pending", 128'(q.size()), 128'(0));
    endtask

    initial begin : main
        int  cnt;
        int  accepted;
        int  cycles;
        bit  acc;
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] slice_max;
        logic [WIDTH-1:0] smax;
        ones      = '1;
        smax      = {1'b0, {(WIDTH-1){1'b1}}};
        slice_max = (WIDTH'(1) << SW) - WIDTH'(1);
        if (STAGES == 1) slice_max = WIDTH'(16'hFFFF);

        // Asynchronous reset values, in_ready high during reset.
        #3;
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_outputs", 128'({RC, c_out, ovf, zero, neg}), 128'(0));
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        repeat (2) @(posedge clock);
        #3;
        clear = 1'b0;
        @(posedge clock);
        #1;
        chk("post_reset_in_ready", 128'(in_ready), 128'(1));

        // Latency from accepting edge to visible result, with a carry crossing a slice.
        drive(1'b1, slice_max, WIDTH'(1), 1'b0, 1'b0, 1'b0, acc);
        chk("latency_accept", 128'(acc), 128'(1));
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            idle();
            cnt++;
        end
        chk("latency_edges", 128'(cnt), 128'(STAGES));
        drain();

        // Boundary operations.
        send(smax, WIDTH'(1), 1'b0, 1'b0, 1'b0);
        send(WIDTH'(5), WIDTH'(5), 1'b1, 1'b0, 1'b0);
        send(ones, '0, 1'b0, 1'b1, 1'b1);
        send(ones, WIDTH'(1), 1'b0, 1'b0, 1'b0);
        send('0, WIDTH'(1), 1'b1, 1'b0, 1'b0);
        send({1'b1, {(WIDTH-1){1'b0}}}, WIDTH'(1), 1'b1, 1'b0, 1'b0);
        send(WIDTH'(3), WIDTH'(7), 1'b1, 1'b1, 1'b0);
        drain();

        // Backpressure: consumer stalls while four ops stream in.
        n_stall = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(WIDTH'(i + 1) << 3, WIDTH'(100 + i), 1'b0, 1'b0, 1'b0);
            end
            begin
                @(negedge clock);
                rmode = 1;
                repeat (STAGES + 3) @(posedge clock);
                rmode = 0;
            end
        join
        drain();
        chk("stall_seen", 128'(n_stall > 0), 128'(1));

        // Reset while results are in flight and presented.
        send(WIDTH'(11), WIDTH'(22), 1'b0, 1'b0, 1'b0);
        send(WIDTH'(33), WIDTH'(44), 1'b0, 1'b0, 1'b0);
        repeat (STAGES - 1) idle();
        chk("pre_clear_out_valid", 128'(out_valid), 128'(1));
        #2;
        clear = 1'b1;
        #1;
        chk("clear_out_valid", 128'(out_valid), 128'(0));
        chk("clear_outputs", 128'({RC, c_out, ovf, zero, neg}), 128'(0));
        chk("clear_in_ready", 128'(in_ready), 128'(1));
        q.delete();
        repeat (2) @(posedge clock);
        #3;
        clear = 1'b0;
        repeat (STAGES + 3) idle();
        chk("no_stale_result", 128'(out_valid), 128'(0));

        // Random traffic with random consumer readiness.
        rmode = 2;
        accepted = 0;
        cycles = 0;
        while (accepted < 10000 && cycles < 60000) begin
            drive(($urandom % 4) != 0, rnd_word(), rnd_word(), 1'($urandom), 1'($urandom),
                  1'($urandom), acc);
            if (acc) accepted++;
            cycles++;
        end
        chk("random_accepted", 128'(accepted), 128'(10000));
        drain();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
